// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Imported by mem_bus_arbiter and rr_arbiter2.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam logic M0_ID       = 1'b0;
  localparam logic M1_ID       = 1'b1;
  localparam int   DEF_TIMEOUT = 15;

  // The counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  function automatic int tmo_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant selection, purely combinational.
// On contention, the master that did not own the previous transfer wins.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_id,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt_id  = M0_ID;
    case (req)
      2'b01:   gnt_id = M0_ID;
      2'b10:   gnt_id = M1_ID;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = M0_ID;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory/IO slave port between M0 (CPU) and M1 (debug/DMA loader).
// Serialises transfers IDLE->BUS->RESP and aborts with an error if the slave hangs.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          sys_rst,

  input  logic          m0_valid,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rdy,
  output logic          m0_err,

  input  logic          m1_valid,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rdy,
  output logic          m1_err,

  output logic          s_valid,
  output logic [AW-1:0] s_addr,
  output logic          s_we,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rdy
);

  localparam int TW = tmo_width(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  bus_state_t    state, state_nxt;
  logic          gnt_id, gnt_id_nxt;
  logic          last_grant, last_grant_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;

  logic [AW-1:0] s_addr_nxt;
  logic          s_we_nxt;
  logic [DW-1:0] s_wdata_nxt;

  logic [DW-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic          m0_rdy_nxt, m1_rdy_nxt;
  logic          m0_err_nxt, m1_err_nxt;

  logic          arb_gnt_id;
  logic          arb_gnt_vld;

  rr_arbiter2 u_rr_arbiter2 (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_grant),
    .gnt_id     (arb_gnt_id),
    .gnt_vld    (arb_gnt_vld)
  );

  // Dropping s_valid as soon as s_rdy arrives keeps the slave from re-sampling the request.
  assign s_valid = (state == BUS) & ~s_rdy;

  always_comb begin
    state_nxt      = state;
    gnt_id_nxt     = gnt_id;
    last_grant_nxt = last_grant;
    tmo_cnt_nxt    = tmo_cnt;
    s_addr_nxt     = s_addr;
    s_we_nxt       = s_we;
    s_wdata_nxt    = s_wdata;
    m0_rdata_nxt   = m0_rdata;
    m1_rdata_nxt   = m1_rdata;
    m0_rdy_nxt     = 1'b0;
    m1_rdy_nxt     = 1'b0;
    m0_err_nxt     = 1'b0;
    m1_err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (arb_gnt_vld) begin
          gnt_id_nxt  = arb_gnt_id;
          tmo_cnt_nxt = '0;
          state_nxt   = BUS;
          if (arb_gnt_id == M1_ID) begin
            s_addr_nxt  = m1_addr;
            s_we_nxt    = m1_we;
            s_wdata_nxt = m1_wdata;
          end else begin
            s_addr_nxt  = m0_addr;
            s_we_nxt    = m0_we;
            s_wdata_nxt = m0_wdata;
          end
        end
      end

      BUS: begin
        if (s_rdy) begin
          state_nxt = RESP;
          if (gnt_id == M1_ID) begin
            m1_rdata_nxt = s_rdata;
            m1_rdy_nxt   = 1'b1;
          end else begin
            m0_rdata_nxt = s_rdata;
            m0_rdy_nxt   = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = RESP;
          if (gnt_id == M1_ID) begin
            m1_rdata_nxt = '0;
            m1_rdy_nxt   = 1'b1;
            m1_err_nxt   = 1'b1;
          end else begin
            m0_rdata_nxt = '0;
            m0_rdy_nxt   = 1'b1;
            m0_err_nxt   = 1'b1;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end

      // Requests are not sampled here, so a master re-asserting valid waits one cycle.
      RESP: begin
        last_grant_nxt = gnt_id;
        state_nxt      = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      gnt_id     <= M0_ID;
      last_grant <= M1_ID;
      tmo_cnt    <= '0;
      s_addr     <= '0;
      s_we       <= 1'b0;
      s_wdata    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_rdy     <= 1'b0;
      m1_rdy     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt_id     <= gnt_id_nxt;
      last_grant <= last_grant_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      s_addr     <= s_addr_nxt;
      s_we       <= s_we_nxt;
      s_wdata    <= s_wdata_nxt;
      m0_rdata   <= m0_rdata_nxt;
      m1_rdata   <= m1_rdata_nxt;
      m0_rdy     <= m0_rdy_nxt;
      m1_rdy     <= m1_rdy_nxt;
      m0_err     <= m0_err_nxt;
      m1_err     <= m1_err_nxt;
    end
  end

endmodule
